// File: rtl/boruss_ram_dma.sv
// Block-transfer engine for the boruss single-port RAM.
// Copies a byte run between regions or fills a region with a constant.
module boruss_ram_dma #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  output logic                  ram_read_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] ONE = 1;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] dst;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH:0]   written;
  logic [DATA_WIDTH-1:0] fill;
  logic                  fill_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      written   <= '0;
      fill      <= '0;
      fill_mode <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        src       <= src_addr;
        dst       <= dst_addr;
        remaining <= length;
        fill      <= fill_value;
        fill_mode <= mode;
        written   <= '0;
      end else if (state == WR) begin
        // pointers wrap naturally at the address width
        src       <= src + 1'b1;
        dst       <= dst + 1'b1;
        remaining <= remaining - ONE;
        written   <= written + ONE;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length == '0)
            next_state = DONE;
          else if (mode)
            next_state = WR;
          else
            next_state = RD;
        end
      end
      RD: next_state = WR;
      WR: begin
        if (remaining == ONE)
          next_state = DONE;
        else if (fill_mode)
          next_state = WR;
        else
          next_state = RD;
      end
      DONE: next_state = IDLE;
    endcase
  end

  // bus is driven only from state and latched registers; idle bus is zero
  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    ram_address      = '0;
    ram_data_in      = '0;
    ram_write_enable = 1'b0;
    ram_read_enable  = 1'b0;
    unique case (state)
      IDLE: ;
      RD: begin
        busy            = 1'b1;
        ram_read_enable = 1'b1;
        ram_address     = src;
      end
      WR: begin
        busy             = 1'b1;
        ram_write_enable = 1'b1;
        ram_address      = dst;
        ram_data_in      = fill_mode ? fill : ram_data_out;
      end
      DONE: done = 1'b1;
    endcase
  end

  assign count = written;

endmodule

// File: tb/tb_boruss_ram_dma.sv
// Bench for boruss_ram_dma: RAM model, reference memory image,
// and a queue scoreboard checked by an independent monitor.
module tb_boruss_ram_dma;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [8:0] length = '0;
  logic [7:0] fill_value = '0;
  logic       busy;
  logic       done;
  logic [8:0] count;
  logic [7:0] ram_address;
  logic [7:0] ram_data_in;
  logic       ram_write_enable;
  logic       ram_read_enable;
  logic [7:0] ram_data_out;

  boruss_ram_dma #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mode(mode),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .length(length),
    .fill_value(fill_value),
    .busy(busy),
    .done(done),
    .count(count),
    .ram_address(ram_address),
    .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable),
    .ram_read_enable(ram_read_enable),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: synchronous write, registered read, cleared by reset
  logic [7:0] mem [256];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      ram_data_out <= 8'h00;
    end else begin
      if (ram_write_enable) mem[ram_address] <= ram_data_in;
      if (ram_read_enable) ram_data_out <= mem[ram_address];
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } acc_t;

  typedef struct {
    int n;
    int c;
  } fin_t;

  acc_t wq[$];
  acc_t rq[$];
  fin_t dq[$];
  logic [7:0] refm [256];
  int tests = 0;
  int fails = 0;
  bit skip = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: protocol every cycle, scoreboard on each access/done
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_write_enable && ram_read_enable) begin
        fails++;
        $display("FAIL proto_both_en at cycle %0d", cyc);
      end
      if (done && busy) begin
        fails++;
        $display("FAIL proto_done_busy at cycle %0d", cyc);
      end
      if (!ram_write_enable && !ram_read_enable &&
          (ram_address != 0 || ram_data_in != 0)) begin
        fails++;
        $display("FAIL idle_bus addr %0h data %0h", ram_address, ram_data_in);
      end
      if (!skip) begin
        if (ram_read_enable) begin
          tests++;
          if (rq.size() == 0) begin
            fails++;
            $display("FAIL rd_unexpected addr %0h cycle %0d", ram_address, cyc);
          end else begin
            acc_t e;
            e = rq.pop_front();
            if (ram_address !== e.a || cyc != e.c) begin
              fails++;
              $display("FAIL rd_access got a=%0h c=%0d expected a=%0h c=%0d",
                       ram_address, cyc, e.a, e.c);
            end
          end
        end
        if (ram_write_enable) begin
          tests++;
          if (wq.size() == 0) begin
            fails++;
            $display("FAIL wr_unexpected addr %0h cycle %0d", ram_address, cyc);
          end else begin
            acc_t e;
            e = wq.pop_front();
            if (ram_address !== e.a || ram_data_in !== e.d || cyc != e.c) begin
              fails++;
              $display("FAIL wr_access got a=%0h d=%0h c=%0d expected a=%0h d=%0h c=%0d",
                       ram_address, ram_data_in, cyc, e.a, e.d, e.c);
            end
          end
        end
        if (done) begin
          tests++;
          if (dq.size() == 0) begin
            fails++;
            $display("FAIL done_unexpected cycle %0d", cyc);
          end else begin
            fin_t e;
            e = dq.pop_front();
            if (count !== 9'(e.n) || cyc != e.c) begin
              fails++;
              $display("FAIL done got count=%0d c=%0d expected count=%0d c=%0d",
                       count, cyc, e.n, e.c);
            end
          end
        end
      end
    end
  end

  // reference: forward byte-wise transfer over an array image
  task automatic transfer(input bit m, input logic [7:0] s,
                          input logic [7:0] d, input int n,
                          input logic [7:0] f, input bit poke);
    int e0;
    int k;
    e0 = cyc + 1;
    for (int i = 0; i < n; i++) begin
      logic [7:0] sa;
      logic [7:0] da;
      logic [7:0] v;
      sa = 8'(int'(s) + i);
      da = 8'(int'(d) + i);
      if (m) begin
        v = f;
        wq.push_back('{a: da, d: v, c: e0 + i});
      end else begin
        v = refm[sa];
        rq.push_back('{a: sa, d: 8'h00, c: e0 + 2 * i});
        wq.push_back('{a: da, d: v, c: e0 + 2 * i + 1});
      end
      refm[da] = v;
    end
    if (n == 0) dq.push_back('{n: 0, c: e0});
    else if (m) dq.push_back('{n: n, c: e0 + n});
    else dq.push_back('{n: n, c: e0 + 2 * n});
    start = 1'b1;
    mode = m;
    src_addr = s;
    dst_addr = d;
    length = 9'(n);
    fill_value = f;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      @(negedge clk);
      start = 1'b1;
      mode = ~m;
      length = 9'd5;
      src_addr = 8'hC0;
      dst_addr = 8'hD0;
      fill_value = 8'hEE;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    k = 0;
    while ((wq.size() != 0 || rq.size() != 0 || dq.size() != 0) && k < 1200) begin
      @(negedge clk);
      k++;
    end
    check("xfer_timeout", 32'(k >= 1200), 32'd0);
    wq.delete();
    rq.delete();
    dq.delete();
    @(negedge clk);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (mem[i] !== refm[i]) bad++;
      check("ram_image", 32'(bad), 32'd0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) refm[i] = 8'h00;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_bus", {ram_address, ram_data_in, 6'd0,
                      ram_write_enable, ram_read_enable}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    transfer(1'b1, 8'h00, 8'h10, 4, 8'hA5, 1'b0);
    check("fill_a5", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]},
          32'hA5A5A5A5);
    check("fill_edge", 32'(mem[8'h14]), 32'h00);
    check("fill_count", 32'(count), 32'd4);

    transfer(1'b1, 8'h00, 8'h20, 1, 8'h11, 1'b0);
    transfer(1'b1, 8'h00, 8'h21, 1, 8'h22, 1'b0);
    transfer(1'b1, 8'h00, 8'h22, 1, 8'h33, 1'b0);
    transfer(1'b0, 8'h20, 8'h40, 3, 8'h00, 1'b0);
    check("copy_data", {8'h00, mem[8'h40], mem[8'h41], mem[8'h42]},
          32'h00112233);

    transfer(1'b1, 8'h00, 8'hFE, 3, 8'h5C, 1'b0);
    check("wrap", {8'h00, mem[8'hFE], mem[8'hFF], mem[8'h00]}, 32'h005C5C5C);
    transfer(1'b0, 8'h12, 8'h34, 0, 8'h00, 1'b0);
    check("zero_count", 32'(count), 32'd0);

    transfer(1'b1, 8'h00, 8'h30, 1, 8'h7E, 1'b0);
    transfer(1'b0, 8'h30, 8'h31, 3, 8'h00, 1'b1);
    check("overlap", {8'h00, mem[8'h31], mem[8'h32], mem[8'h33]},
          32'h007E7E7E);
    check("poke_count", 32'(count), 32'd3);

    // reset in the middle of an 8-byte copy
    skip = 1'b1;
    start = 1'b1;
    mode = 1'b0;
    src_addr = 8'h00;
    dst_addr = 8'h80;
    length = 9'd8;
    @(negedge clk);
    start = 1'b0;
    begin
      int k;
      k = 0;
      while (!(ram_write_enable && count == 9'd2) && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("rst_mid_reach", 32'(k >= 50), 32'd0);
    end
    reset = 1'b1;
    #1;
    check("rst_mid_en", {30'd0, ram_write_enable, ram_read_enable}, 32'd0);
    check("rst_mid_flags", {30'd0, busy, done}, 32'd0);
    check("rst_mid_count", 32'(count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) refm[i] = 8'h00;
    @(negedge clk);
    skip = 1'b0;
    transfer(1'b1, 8'h00, 8'h50, 2, 8'h9D, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int r;
      int n;
      r = $urandom_range(0, 9);
      n = (r == 0) ? 0 : (r == 1) ? 256 : $urandom_range(1, 24);
      transfer(1'($urandom), 8'($urandom), 8'($urandom), n, 8'($urandom),
               1'($urandom_range(0, 3) == 0 && n > 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
